operand_stage: RTL and testbench



---
 rtl/operand_stage_if.sv | 38 +++
 rtl/operand_stage.sv | 65 ++++++
 tb/tb_operand_stage.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/operand_stage_if.sv
// Bus bundle for operand_stage: decoded-instruction input, writeback port and ALU-side output.
// Handshake: a transfer occurs on a rising edge where valid && ready; valid never waits on ready.
interface operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [15:0]       imm;
  logic              alu_src;
  logic              imm_zext;
  logic [3:0]        alu_op_in;
  logic              flush;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] X;
  logic [DATA_W-1:0] Y;
  logic [3:0]        ALUOp;
  logic [ADDR_W-1:0] rd_out;

  modport slave (
    input  in_valid, rs, rt, rd, imm, alu_src, imm_zext, alu_op_in, flush,
    input  wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, X, Y, ALUOp, rd_out
  );

  modport master (
    output in_valid, rs, rt, rd, imm, alu_src, imm_zext, alu_op_in, flush,
    output wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, X, Y, ALUOp, rd_out
  );
endinterface

// File: rtl/operand_stage.sv
// Operand-fetch stage: register file, immediate extension and a one-entry output register for the ALU.
// Optional macro REG_BYPASS_EN forwards a same-edge writeback into the captured operands.
module operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic           clk,
  input logic           rst,
  operand_stage_if.slave bus
);
  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] x_rd;
  logic [DATA_W-1:0] y_rd;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] y_sel;
  logic              capture;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != '0) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    x_rd = (bus.rs == '0) ? '0 : regs[bus.rs];
    y_rd = (bus.rt == '0) ? '0 : regs[bus.rt];
`ifdef REG_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == bus.rs && bus.rs != '0) x_rd = bus.wb_data;
    if (bus.wb_en && bus.wb_addr == bus.rt && bus.rt != '0 && !bus.alu_src) y_rd = bus.wb_data;
`endif
  end

  assign imm_ext = bus.imm_zext ? {{(DATA_W-16){1'b0}}, bus.imm}
                                : {{(DATA_W-16){bus.imm[15]}}, bus.imm};
  assign y_sel   = bus.alu_src ? imm_ext : y_rd;

  assign bus.in_ready = !bus.flush && (!bus.out_valid || bus.out_ready);
  assign capture      = bus.in_valid && bus.in_ready;

  // Flush wins over drain; operands hold their last values when the entry empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.X         <= '0;
      bus.Y         <= '0;
      bus.ALUOp     <= '0;
      bus.rd_out    <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (capture) begin
      bus.out_valid <= 1'b1;
      bus.X         <= x_rd;
      bus.Y         <= y_sel;
      bus.ALUOp     <= bus.alu_op_in;
      bus.rd_out    <= bus.rd;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed vector table, hand-written stall/reset sequences,
// then randomized traffic against a transaction-level reference model.
module tb_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] BX = BYP ? 32'h0000_1234 : 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_stage_if #(.DATA_W(DW), .ADDR_W(AW)) b();
  operand_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(b));

  int tests = 0;
  int fails = 0;
  logic [31:0] m_regs [32];
  logic [72:0] exp_q [$];

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        in_valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        alu_src;
    logic        imm_zext;
    logic [3:0]  op;
    logic        flush;
    logic        e_rdy;
    logic        e_valid;
    logic [31:0] e_x;
    logic [31:0] e_y;
    logic [3:0]  e_op;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ext(input logic [15:0] imm, input logic zext);
    logic signed [31:0] s;
    s = $signed(imm);
    return zext ? {16'h0, imm} : s;
  endfunction

  // Register read as the ALU should see it at a capturing edge.
  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && b.wb_en && b.wb_addr == a) return b.wb_data;
    return m_regs[a];
  endfunction

  task automatic clear_inputs();
    b.in_valid = 1'b0; b.rs = '0; b.rt = '0; b.rd = '0; b.imm = '0;
    b.alu_src = 1'b0; b.imm_zext = 1'b0; b.alu_op_in = '0; b.flush = 1'b0;
    b.wb_en = 1'b0; b.wb_addr = '0; b.wb_data = '0; b.out_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && b.wb_en && b.wb_addr != 5'd0) m_regs[b.wb_addr] = b.wb_data;
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    b.wb_en = v.wb_en; b.wb_addr = v.wb_addr; b.wb_data = v.wb_data;
    b.in_valid = v.in_valid; b.rs = v.rs; b.rt = v.rt; b.rd = v.rd; b.imm = v.imm;
    b.alu_src = v.alu_src; b.imm_zext = v.imm_zext; b.alu_op_in = v.op;
    b.flush = v.flush; b.out_ready = 1'b1;
    #1;
    check($sformatf("vec%0d_in_ready", idx), b.in_ready, v.e_rdy);
    tick();
    check($sformatf("vec%0d_out_valid", idx), b.out_valid, v.e_valid);
    check($sformatf("vec%0d_xy_op_rd", idx), {b.X, b.Y, b.ALUOp, b.rd_out},
          {v.e_x, v.e_y, v.e_op, v.e_rd});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_rdy;
    tbl[0]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd1,  16'h0,    1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        4'h0, 5'd1};
    tbl[1]  = '{1'b1, 5'd5,  32'hAA,       1'b0, 5'd0,  5'd0,  5'd0,  16'h0,    1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        4'h0, 5'd1};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd0,  5'd2,  16'hFFFF, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hAA,       32'hFFFF_FFFF, 4'h0, 5'd2};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd0,  5'd3,  16'hFFFF, 1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 32'hAA,       32'h0000_FFFF, 4'h3, 5'd3};
    tbl[4]  = '{1'b1, 5'd3,  32'h1234,     1'b1, 5'd3,  5'd3,  5'd4,  16'h0,    1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, BX,           BX,           4'h1, 5'd4};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd0,  5'd5,  16'h0,    1'b0, 1'b0, 4'h2, 1'b0, 1'b1, 1'b1, 32'h1234,     32'h0,        4'h2, 5'd5};
    tbl[6]  = '{1'b1, 5'd0,  32'hDEAD,     1'b1, 5'd0,  5'd0,  5'd6,  16'h0,    1'b0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        4'h5, 5'd6};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd5,  5'd7,  16'h0,    1'b0, 1'b0, 4'h6, 1'b0, 1'b1, 1'b1, 32'h0,        32'hAA,       4'h6, 5'd7};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd0,  16'h0,    1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0,        32'hAA,       4'h6, 5'd7};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  5'd3,  5'd8,  16'h0,    1'b0, 1'b0, 4'h7, 1'b0, 1'b1, 1'b1, 32'hAA,       32'h1234,     4'h7, 5'd8};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd9,  16'h0,    1'b0, 1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 32'hAA,       32'h1234,     4'h7, 5'd8};
    tbl[11] = '{1'b1, 5'd31, 32'hCAFE_F00D, 1'b1, 5'd3, 5'd0,  5'd31, 16'h8000, 1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 32'h1234,     32'hFFFF_8000, 4'hF, 5'd31};
    tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd31, 5'd0,  16'h0,    1'b0, 1'b0, 4'hE, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'hE, 5'd0};

    // Reset state with all inputs low.
    do_reset();
    check("reset_out_valid", b.out_valid, 1'b0);
    check("reset_outputs", {b.X, b.Y, b.ALUOp, b.rd_out}, 73'h0);
    check("reset_in_ready", b.in_ready, 1'b1);

    for (int i = 0; i < 13; i++) apply_vec(i, tbl[i]);

    // Stall: load A, then hold B at the input while the ALU is not ready.
    clear_inputs();
    b.in_valid = 1'b1; b.rs = 5'd5; b.alu_op_in = 4'hA; b.rd = 5'd10; b.out_ready = 1'b1;
    tick();
    check("stall_load_a", {b.out_valid, b.X, b.ALUOp}, {1'b1, 32'hAA, 4'hA});
    b.rs = 5'd3; b.rt = 5'd3; b.alu_op_in = 4'hB; b.rd = 5'd11; b.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d_in_ready", c), b.in_ready, 1'b0);
      tick();
      check($sformatf("stall%0d_held", c), {b.out_valid, b.X, b.Y, b.ALUOp, b.rd_out},
            {1'b1, 32'hAA, 32'h0, 4'hA, 5'd10});
    end
    b.out_ready = 1'b1;
    #1;
    check("stall_release_in_ready", b.in_ready, 1'b1);
    tick();
    check("stall_capture_b", {b.out_valid, b.X, b.Y, b.ALUOp, b.rd_out},
          {1'b1, 32'h1234, 32'h1234, 4'hB, 5'd11});

    // Asynchronous reset mid-stream clears outputs at once and empties the register file.
    #2 rst = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    #1;
    check("midreset_outputs", {b.out_valid, b.X, b.Y, b.ALUOp, b.rd_out}, 74'h0);
    tick();
    #2 rst = 1'b0;
    clear_inputs();
    b.in_valid = 1'b1; b.rs = 5'd5; b.rt = 5'd3; b.out_ready = 1'b1;
    #1;
    tick();
    check("midreset_regs_cleared", {b.out_valid, b.X, b.Y}, {1'b1, 32'h0, 32'h0});

    // Randomized traffic against the expected-result queue.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      b.in_valid  = 1'($urandom_range(0, 1));
      b.rs        = 5'($urandom_range(0, 7));
      b.rt        = 5'($urandom_range(0, 7));
      b.rd        = 5'($urandom_range(0, 31));
      b.imm       = 16'($urandom);
      b.alu_src   = 1'($urandom_range(0, 1));
      b.imm_zext  = 1'($urandom_range(0, 1));
      b.alu_op_in = 4'($urandom_range(0, 15));
      b.flush     = ($urandom_range(0, 7) == 0);
      b.out_ready = ($urandom_range(0, 3) != 0);
      b.wb_en     = 1'($urandom_range(0, 1));
      b.wb_addr   = 5'($urandom_range(0, 7));
      b.wb_data   = $urandom;
      #1;
      exp_rdy = !b.flush && (exp_q.size() == 0 || b.out_ready);
      check("rand_in_ready", b.in_ready, exp_rdy);
      check("rand_out_valid", b.out_valid, exp_q.size() != 0);
      if (b.flush) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (exp_q.size() != 0 && b.out_ready) begin
        check("rand_result", {b.X, b.Y, b.ALUOp, b.rd_out}, exp_q.pop_front());
      end
      if (b.in_valid && exp_rdy)
        exp_q.push_back({mread(b.rs), b.alu_src ? ext(b.imm, b.imm_zext) : mread(b.rt),
                         b.alu_op_in, b.rd});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
